// File: rtl/heartbeat.sv
// Free-running heartbeat: an N-bit counter that emits a one-cycle pulse on
// the edge after it reaches all-ones, i.e. once every 2^N clock cycles.
`timescale 1ns/1ps
module heartbeat #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic nreset,
   output logic out
);

   localparam logic [N-1:0] CNT_ONE  = N'(1'b1);
   localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
   localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

   logic [N-1:0] cnt;
   logic         wrap_s;

   // Terminal-count decode of the pre-edge counter value.
   always_comb begin
      wrap_s = 1'b0;
      if (cnt == CNT_MAX) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
   end

   // Period counter; the all-ones to zero wrap is the start of the next period.
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         cnt <= CNT_ZERO;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Pulse register so out never depends combinationally on any input.
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         out <= 1'b0;
      end else begin
         out <= wrap_s;
      end
   end

endmodule

// File: tb/tb_heartbeat.sv
// Bench for heartbeat: three instances (N=8, 4, 1) checked every cycle against
// an edge-count model, with directed and random asynchronous reset hits.
`timescale 1ns/1ps
module tb_heartbeat;

   logic clk = 1'b0;
   logic rst8, rst4, rst1;
   logic out8, out4, out1;

   heartbeat #(.N(8)) u8 (.clk(clk), .nreset(rst8), .out(out8));
   heartbeat #(.N(4)) u4 (.clk(clk), .nreset(rst4), .out(out4));
   heartbeat #(.N(1)) u1 (.clk(clk), .nreset(rst1), .out(out1));

   always #1 clk = ~clk;

   // Model state: rising edges seen since the last edge that found reset high.
   longint k8 = 0;
   longint k4 = 0;
   longint k1 = 0;
   int     errors  = 0;
   int     checks  = 0;
   int     pulses8 = 0;
   bit     running = 1'b1;
   bit     first1  = 1'b1;
   logic   seq1 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   function automatic logic exp_out(input longint k, input int n);
      longint p;
      p = longint'(1) << n;
      return (k > 0) && ((k % p) == 0);
   endfunction

   function automatic longint exp_cnt(input longint k, input int n);
      longint p;
      p = longint'(1) << n;
      return k % p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count edges since reset per instance.
   always @(posedge clk) begin
      k8 = rst8 ? 0 : k8 + 1;
      k4 = rst4 ? 0 : k4 + 1;
      k1 = rst1 ? 0 : k1 + 1;
   end

   // Compare process: every negedge, outputs and counter vs model.
   always @(negedge clk) begin
      if (running) begin
         chk("out8", out8, rst8 ? 1'b0 : exp_out(k8, 8));
         chk("cnt8", u8.cnt, exp_cnt(k8, 8));
         chk("out4", out4, rst4 ? 1'b0 : exp_out(k4, 4));
         chk("cnt4", u4.cnt, exp_cnt(k4, 4));
         chk("out1", out1, rst1 ? 1'b0 : exp_out(k1, 1));
         chk("cnt1", u1.cnt, exp_cnt(k1, 1));
         if (out8 === 1'b1) pulses8++;
         if (!rst8 && k8 == 64) chk("pin_cnt8_64", u8.cnt, 64'd64);
         if (!rst4 && (k4 == 16 || k4 == 32)) chk("pin_out4_pulse", out4, 1'b1);
         if (first1 && !rst1 && k1 >= 1 && k1 <= 6) begin
            chk("pin_seq1", out1, seq1[int'(k1) - 1]);
            if (k1 == 6) first1 = 1'b0;
         end
      end
   end

   task automatic n4_proc();
      repeat (40) @(negedge clk);
      // Walk to cnt=9, then hit reset between edges.
      for (int i = 0; i < 20 && (k4 % 16) != 9; i++) @(negedge clk);
      chk("reach_cnt9", k4 % 16, 64'd9);
      #0.5 rst4 = 1'b1;
      #0.1 chk("rst_mid_out4", out4, 1'b0);
      chk("rst_mid_cnt4", u4.cnt, 64'd0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #0.5 rst4 = 1'b0;
      // Walk to the first pulse after release, then hit reset during it.
      for (int i = 0; i < 40 && k4 != 16; i++) @(negedge clk);
      chk("reach_pulse4", k4, 64'd16);
      #0.5 rst4 = 1'b1;
      #0.1 chk("rst_pulse_out4", out4, 1'b0);
      chk("rst_pulse_cnt4", u4.cnt, 64'd0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #0.5 rst4 = 1'b0;
      repeat (8) begin
         repeat ($urandom_range(5, 40)) @(negedge clk);
         #0.5 rst4 = 1'b1;
         #0.1 chk("rst_rand_out4", out4, 1'b0);
         chk("rst_rand_cnt4", u4.cnt, 64'd0);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         #0.5 rst4 = 1'b0;
      end
   endtask

   task automatic n1_proc();
      repeat (10) @(negedge clk);
      repeat (10) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         #0.5 rst1 = 1'b1;
         #0.1 chk("rst_rand_out1", out1, 1'b0);
         chk("rst_rand_cnt1", u1.cnt, 64'd0);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         #0.5 rst1 = 1'b0;
      end
   endtask

   initial begin
      rst8 = 1'b1;
      rst4 = 1'b1;
      rst1 = 1'b1;
      repeat (3) @(negedge clk);
      #0.5;
      rst8 = 1'b0;
      rst4 = 1'b0;
      rst1 = 1'b0;
      fork
         repeat (600) @(negedge clk);
         n4_proc();
         n1_proc();
      join
      chk("pulses8", pulses8, 64'd2);
      running = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
